fetch_queue: RTL and testbench

Fetch-side owner of the program counter and the instruction-pair queue feeding dual-issue decode. Drives the byte address into the 2 KB instruction memory, which returns two 32-bit instructions (PC, PC+4) one cycle later. Captures each returned pair with its PC into a small FIFO and presents the oldest pair to decode through a valid/ready handshake. Handles decode back-pressure and branch redirect/flush.

---
 rtl/fetch_queue.sv | 105 ++++++++++
 tb/tb_fetch_queue.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Fetch-side PC owner and instruction-pair queue for dual-issue decode.
// Fetch-to-decode is two cycles. Fetch issues only when a slot is free, so decode stalls throttle it.
module fetch_queue #(
   parameter int DEPTH      = 4,
   parameter int IMEM_BYTES = 2048
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_pc,
   input  logic [31:0] imem_instr1,
   input  logic [31:0] imem_instr2,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        dec_valid,
   output logic        dec_valid2,
   input  logic        dec_ready,
   output logic [31:0] dec_instr1,
   output logic [31:0] dec_instr2,
   output logic [31:0] dec_pc
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [31:0] instr1;
      logic [31:0] instr2;
      logic [31:0] pc;
      logic        single;
   } entry_t;

   entry_t          store [DEPTH];
   entry_t          head;
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic [CW-1:0]   count;
   logic [31:0]     pc;
   logic [31:0]     inflight_pc;
   logic            inflight;
   logic            inflight_single;

   logic            issue;
   logic            wr_en;
   logic            rd_en;
   logic            at_last_word;
   logic            at_last_pair;

   // Credit check counts the pair still in flight so a capture always has room.
   assign issue        = !redirect_valid && ((32'(count) + 32'(inflight)) < DEPTH);
   assign wr_en        = inflight && !redirect_valid;
   assign rd_en        = dec_valid && dec_ready && !redirect_valid;
   assign at_last_word = (pc == 32'(IMEM_BYTES - 4));
   assign at_last_pair = (pc == 32'(IMEM_BYTES - 8));

   always_ff @(posedge clk) begin
      if (reset) begin
         pc              <= '0;
         inflight        <= 1'b0;
         inflight_pc     <= '0;
         inflight_single <= 1'b0;
         rd_ptr          <= '0;
         wr_ptr          <= '0;
         count           <= '0;
      end else if (redirect_valid) begin
         pc       <= redirect_pc & ~32'h3;
         inflight <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (issue) begin
            inflight        <= 1'b1;
            inflight_pc     <= pc;
            inflight_single <= at_last_word;
            pc              <= (at_last_word || at_last_pair) ? 32'd0 : pc + 32'd8;
         end else begin
            inflight <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && wr_en) begin
         assert (count != CW'(DEPTH));
         store[wr_ptr] <= '{instr1: imem_instr1, instr2: imem_instr2,
                            pc: inflight_pc, single: inflight_single};
      end
   end

   assign head       = store[rd_ptr];
   assign imem_pc    = pc;
   assign dec_valid  = (count != '0);
   assign dec_valid2 = dec_valid && !head.single;
   assign dec_instr1 = dec_valid ? head.instr1 : 32'd0;
   assign dec_instr2 = dec_valid ? head.instr2 : 32'd0;
   assign dec_pc     = dec_valid ? head.pc     : 32'd0;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random decode/redirect traffic,
// every cycle compared against a queue-based reference model.
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] imem_pc;
   logic [31:0] imem_instr1 = '0;
   logic [31:0] imem_instr2 = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        dec_valid;
   logic        dec_valid2;
   logic        dec_ready = 1'b0;
   logic [31:0] dec_instr1;
   logic [31:0] dec_instr2;
   logic [31:0] dec_pc;

   int errors = 0;
   int checks = 0;

   fetch_queue #(.DEPTH(4), .IMEM_BYTES(2048)) dut (
      .clk(clk), .reset(reset), .imem_pc(imem_pc),
      .imem_instr1(imem_instr1), .imem_instr2(imem_instr2),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .dec_valid(dec_valid), .dec_valid2(dec_valid2), .dec_ready(dec_ready),
      .dec_instr1(dec_instr1), .dec_instr2(dec_instr2), .dec_pc(dec_pc)
   );

   always #5 clk = ~clk;

   // Memory word n holds n.
   function automatic logic [31:0] word(input logic [31:0] addr);
      return 32'((addr % 32'd2048) / 32'd4);
   endfunction

   always @(posedge clk) begin
      imem_instr1 <= word(imem_pc);
      imem_instr2 <= word(imem_pc + 32'd4);
   end

   typedef struct {
      logic [31:0] pc;
      bit          single;
   } ment_t;

   ment_t       q[$];
   logic [31:0] m_pc = '0;
   logic [31:0] m_inf_pc = '0;
   bit          m_inf = 1'b0;
   bit          m_inf_single = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      bit v;
      v = (q.size() != 0);
      chk("imem_pc",    imem_pc, m_pc);
      chk("dec_valid",  32'(dec_valid), 32'(v));
      chk("dec_valid2", 32'(dec_valid2), 32'(v && !q[0].single));
      chk("dec_pc",     dec_pc,     v ? q[0].pc : 32'd0);
      chk("dec_instr1", dec_instr1, v ? word(q[0].pc) : 32'd0);
      chk("dec_instr2", dec_instr2, v ? word(q[0].pc + 32'd4) : 32'd0);
   endtask

   // Advance the model by one cycle using the inputs held for this cycle, then clock the DUT.
   task automatic step();
      ment_t e;
      if (reset || redirect_valid) begin
         q.delete();
         m_inf = 1'b0;
         m_pc  = reset ? 32'd0 : (redirect_pc & ~32'h3);
      end else begin
         bit issue;
         issue = (q.size() + int'(m_inf)) < 4;
         if (q.size() != 0 && dec_ready) void'(q.pop_front());
         if (m_inf) begin
            e.pc     = m_inf_pc;
            e.single = m_inf_single;
            q.push_back(e);
         end
         if (issue) begin
            m_inf        = 1'b1;
            m_inf_pc     = m_pc;
            m_inf_single = (m_pc == 32'd2044);
            m_pc         = (m_pc == 32'd2044 || m_pc == 32'd2040) ? 32'd0 : m_pc + 32'd8;
         end else begin
            m_inf = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      check_model();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   initial begin
      #2;
      // Reset state and streaming
      dec_ready = 1'b1;
      do_reset();
      chk("rst_valid", 32'(dec_valid), 32'd0);
      chk("rst_imem_pc", imem_pc, 32'd0);
      step();
      step();
      for (int k = 0; k < 12; k++) begin
         chk("stream_pc", dec_pc, 32'(8 * k));
         chk("stream_v2", 32'(dec_valid2), 32'd1);
         step();
      end

      // Redirect while streaming
      redirect_valid = 1'b1;
      redirect_pc    = 32'h106;
      step();
      redirect_valid = 1'b0;
      chk("redir_flush", 32'(dec_valid), 32'd0);
      step();
      step();
      chk("redir_pc0", dec_pc, 32'h104);
      step();
      chk("redir_pc1", dec_pc, 32'h10C);

      // Wrap at end of memory
      redirect_valid = 1'b1;
      redirect_pc    = 32'h7FC;
      step();
      redirect_valid = 1'b0;
      step();
      step();
      chk("wrap_pc", dec_pc, 32'h7FC);
      chk("wrap_v2", 32'(dec_valid2), 32'd0);
      step();
      chk("wrap_pc_next", dec_pc, 32'h000);
      chk("wrap_v2_next", 32'(dec_valid2), 32'd1);

      // Back-pressure fill and release
      dec_ready = 1'b0;
      do_reset();
      for (int k = 0; k < 10; k++) step();
      chk("bp_head", dec_pc, 32'd0);
      chk("bp_imem_pc", imem_pc, 32'd32);
      chk("bp_queued", 32'(q.size()), 32'd4);
      dec_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         chk("bp_valid", 32'(dec_valid), 32'd1);
         chk("bp_release_pc", dec_pc, 32'(8 * k));
         step();
      end

      // Reset with a full queue
      dec_ready = 1'b0;
      for (int k = 0; k < 8; k++) step();
      do_reset();
      chk("mid_rst_valid", 32'(dec_valid), 32'd0);
      chk("mid_rst_v2", 32'(dec_valid2), 32'd0);
      chk("mid_rst_pc", dec_pc, 32'd0);
      chk("mid_rst_i1", dec_instr1, 32'd0);
      chk("mid_rst_imem", imem_pc, 32'd0);
      step();
      step();
      chk("mid_rst_after", 32'(dec_valid), 32'd1);
      chk("mid_rst_after_pc", dec_pc, 32'd0);

      // Redirect colliding with a pop, three entries queued
      do_reset();
      for (int k = 0; k < 4; k++) step();
      chk("coll_queued", 32'(q.size()), 32'd3);
      dec_ready      = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      step();
      redirect_valid = 1'b0;
      chk("coll_empty", 32'(dec_valid), 32'd0);
      step();
      chk("coll_empty2", 32'(dec_valid), 32'd0);
      step();
      chk("coll_new_pc", dec_pc, 32'h40);

      // Random traffic
      for (int k = 0; k < 400; k++) begin
         dec_ready      = ($urandom_range(0, 9) < 7);
         redirect_valid = ($urandom_range(0, 19) == 0);
         redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'h7F0 | 32'($urandom_range(0, 15)))
                                                      : 32'($urandom_range(0, 2047));
         reset          = ($urandom_range(0, 99) == 0);
         step();
      end
      reset          = 1'b0;
      redirect_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
